mm2fifo: RTL and testbench
==========================

# mm2fifo

AXI4 burst read master that fetches image frames from memory at `base_addr` and pushes them, one beat per data word, into a downstream FIFO write port. It is the read-side counterpart of the stream-to-memory writer: it refills a display or processing FIFO with full frames, marking the first word of each frame with `sof` and pulsing `frame_pulse` when a frame has been fully fetched. Frame size must be an integral multiple of one burst (`C_M_AXI_BURST_LEN` beats × `C_ADATA_PIXELS` pixels), and bursts never cross a 4 KB boundary.

## Interface
Parameters:
- `C_DATACOUNT_BITS`, 12: width of the FIFO write data count.
- `C_FIFO_DEPTH`, 2048: depth of the downstream FIFO, in words.
- `C_M_AXI_BURST_LEN`, 16: beats per burst (1, 2, 4, … 256).
- `C_M_AXI_ID_WIDTH`, 1: AXI ID width.
- `C_M_AXI_ADDR_WIDTH`, 32: AXI address width.
- `C_M_AXI_DATA_WIDTH`, 32: AXI data width and FIFO word width.
- `C_IMG_WBITS` / `C_IMG_HBITS`, 12 / 12: width and height counter widths.
- `C_ADATA_PIXELS`, 4: pixels carried per data word.

Ports:
- `M_AXI_ACLK`, in, 1: the single clock.
- `M_AXI_ARESETN`, in, 1: reset, asynchronous, active-low.
- `soft_resetn`, in, 1: soft reset, active-low.
- `resetting`, out, 1: high while a soft reset is draining.
- `img_width`, in, `C_IMG_WBITS`: frame width in pixels.
- `img_height`, in, `C_IMG_HBITS`: frame height in lines.
- `base_addr`, in, `C_M_AXI_ADDR_WIDTH`: frame start address.
- `frame_pulse`, out, 1: one-cycle pulse when a frame has been fetched.
- `dout`, out, `C_M_AXI_DATA_WIDTH`: FIFO write data.
- `sof`, out, 1: marks the first word of a frame.
- `wr_en`, out, 1: FIFO write enable.
- `wr_data_count`, in, `C_DATACOUNT_BITS`: current FIFO occupancy.
- AR channel: `M_AXI_ARID`, `M_AXI_ARADDR`, `M_AXI_ARLEN`[8], `M_AXI_ARSIZE`[3], `M_AXI_ARBURST`[2], `M_AXI_ARLOCK`, `M_AXI_ARCACHE`[4], `M_AXI_ARPROT`[3], `M_AXI_ARQOS`[4] are outputs; `M_AXI_ARVALID` is an output; `M_AXI_ARREADY` is an input.
- R channel: `M_AXI_RID`, `M_AXI_RDATA`, `M_AXI_RRESP`[2], `M_AXI_RLAST`, `M_AXI_RVALID` are inputs; `M_AXI_RREADY` is an output.
- `rresp_err`, out, 1: one-cycle pulse on any beat with `RRESP[1]` set.

## Operation
- AR constants:
  - ARID = 0; ARLEN = BURST_LEN−1; ARSIZE = clogb2(DATA_WIDTH/8−1).
  - ARBURST = INCR (01); ARLOCK = 0; ARCACHE = 0010; ARPROT = 0; ARQOS = 0.
- States: IDLE, ADDR, DATA, plus a one-cycle START pulse state between IDLE and ADDR.
- IDLE → START when all of the following hold:
  - `soft_resetn` = 1 and `resetting` = 0;
  - `img_width` ≠ 0 and `img_height` ≠ 0;
  - free space (`C_FIFO_DEPTH − wr_data_count`) ≥ BURST_LEN.
- START:
  - loads the address: `base_addr` if at frame start, else previous address + BURST_LEN×DATA_WIDTH/8;
  - loads the beat counter to BURST_LEN−1;
  - goes to ADDR.
- ADDR: ARVALID = 1 until ARREADY; then go to DATA.
- DATA:
  - RREADY = 1 continuously; the space check in IDLE guarantees the FIFO cannot overflow.
  - Each RVALID beat decrements the beat counter.
  - The beat carrying RLAST returns the block to IDLE.
- FIFO write path: `wr_en` = RVALID & RREADY & ~`resetting`; `dout` = RDATA.
- Frame position:
  - Column and row counters reload to (`img_width` − `C_ADATA_PIXELS`, `img_height` − 1) at START when at frame start.
  - They decrement per written beat, column first, and hold at (0,0).
  - "Frame start" means both counters = 0.
  - `sof` = `wr_en` & first beat of the first burst of a frame (a flag set at START-at-frame-start, cleared on the first beat).
- `frame_pulse`: registered, high one cycle after the beat that takes the counters to (0,0).
- Soft reset:
  - A falling edge of `soft_resetn` sets `resetting` if a burst is in flight (START/ADDR/DATA); otherwise `resetting` stays 0.
  - While `resetting` = 1, the in-flight burst completes on AXI (ARVALID held, RREADY = 1) but nothing is written to the FIFO.
  - `resetting` clears on the RLAST beat.
  - `soft_resetn` = 0 forces the frame counters to 0, so the next frame starts at `base_addr`.
- RLAST ends the burst regardless of the beat counter. If RLAST is not coincident with beat counter = 0, `rresp_err` pulses.

## Timing
- Reset values:
  - ARVALID = 0, RREADY = 0, ARADDR = 0;
  - `wr_en` = 0, `sof` = 0, `frame_pulse` = 0, `rresp_err` = 0;
  - `resetting` = 1 during ARESETN low, clearing the cycle after release;
  - state = IDLE.
- ARVALID rises 2 cycles after the IDLE space check passes (IDLE→START→ADDR).
- ARVALID is held stable with constant ARADDR until ARREADY. ARREADY is honoured on the same cycle ARVALID first rises.
- RREADY rises the cycle after the AR handshake and falls the cycle after the RLAST handshake.
- R → FIFO path: zero latency, combinational.
- Minimum gap between bursts: 2 idle cycles. Only one burst is outstanding at a time.
- `wr_data_count` is sampled only in IDLE.

## Structure
- `mm2fifo_pkg` holds:
  - the state enum;
  - `clogb2`;
  - the AXI constant encodings (INCR, ARCACHE 0010).
- One sub-module, `img_pos_counter`: the column/row down-counter with load/decrement/clear and a `final` flag. It is shareable with the writer.

## Test plan
- 8×2 image, 4 pixels/word, BURST_LEN 2, `base_addr` 0x1000, ARREADY/RVALID always 1:
  - ARADDR sequence 0x1000, 0x1008;
  - 4 `wr_en` beats;
  - `sof` on beat 0 only;
  - `frame_pulse` 1 cycle after beat 3;
  - next ARADDR 0x1000.
- `wr_data_count` = DEPTH − BURST_LEN + 1 → no ARVALID. Drop the count by 1 → ARVALID appears 2 cycles later.
- ARREADY delayed 5 cycles → ARVALID and ARADDR stable throughout; RREADY only after the handshake.
- `soft_resetn` pulse low mid-DATA:
  - `resetting` = 1;
  - remaining beats accepted with `wr_en` = 0;
  - `resetting` clears after RLAST;
  - next burst at `base_addr` with `sof`.
- RRESP = 10 on one beat → `rresp_err` 1 cycle and data still written. RLAST early at beat 1 of 16 → return to IDLE plus `rresp_err`.
- ARESETN asserted mid-burst → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/mm2fifo_pkg.sv
// Shared types and AXI encodings for the frame reader and its position counter.
package mm2fifo_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_ADDR, ST_DATA} state_t;

  localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
  localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0010;

  // Number of bits needed to hold value (0 for value 0).
  function automatic int clogb2(input int value);
    int v;
    int n;
    n = 0;
    v = value;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/img_pos_counter.sv
// Column/row down-counter tracking a beat's position in a frame; is_final is
// combinational with the beat that lands on the last word, at_start is registered.
module img_pos_counter #(
  parameter int W_BITS = 12,
  parameter int H_BITS = 12,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              dec,
  input  logic [W_BITS-1:0] width,
  input  logic [H_BITS-1:0] height,
  output logic [W_BITS-1:0] col,
  output logic [H_BITS-1:0] row,
  output logic              at_start,
  output logic              is_final
);

  localparam logic [W_BITS-1:0] STEP_W = W_BITS'(STEP);

  // armed separates "sitting on the last word" from "frame done", which both read (0,0).
  logic armed;

  assign at_start = ~armed;
  assign is_final = dec & armed & (col < STEP_W) & (row == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      row   <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      col   <= '0;
      row   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      col   <= width - STEP_W;
      row   <= height - H_BITS'(1);
      armed <= 1'b1;
    end else if (dec && armed) begin
      if (col >= STEP_W) begin
        col <= col - STEP_W;
      end else if (row != '0) begin
        row <= row - H_BITS'(1);
        col <= width - STEP_W;
      end else begin
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mm2fifo.sv
// AXI4 burst reader refilling a FIFO with whole frames; R beats reach the FIFO with zero latency.
// A burst is only issued when the FIFO has room for all of it, so RREADY never needs to drop mid-burst.
module mm2fifo
  import mm2fifo_pkg::*;
#(
  parameter int C_DATACOUNT_BITS    = 12,
  parameter int C_FIFO_DEPTH        = 2048,
  parameter int C_M_AXI_BURST_LEN   = 16,
  parameter int C_M_AXI_ID_WIDTH    = 1,
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_M_AXI_DATA_WIDTH  = 32,
  parameter int C_IMG_WBITS         = 12,
  parameter int C_IMG_HBITS         = 12,
  parameter int C_ADATA_PIXELS      = 4
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          soft_resetn,
  output logic                          resetting,
  input  logic [C_IMG_WBITS-1:0]        img_width,
  input  logic [C_IMG_HBITS-1:0]        img_height,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  output logic                          frame_pulse,
  output logic [C_M_AXI_DATA_WIDTH-1:0] dout,
  output logic                          sof,
  output logic                          wr_en,
  input  logic [C_DATACOUNT_BITS-1:0]   wr_data_count,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic                          rresp_err
);

  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int CW    = C_DATACOUNT_BITS + 1;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
    C_M_AXI_ADDR_WIDTH'(C_M_AXI_BURST_LEN * BYTES);
  localparam logic [7:0] LAST_BEAT = 8'(C_M_AXI_BURST_LEN - 1);
  localparam logic [2:0] SIZE_ENC  = 3'(clogb2(BYTES - 1));

  state_t                   state;
  logic [7:0]               beat_cnt;
  logic                     sof_pend;
  logic                     soft_d;
  logic                     r_hs;
  logic                     space_ok;
  logic                     soft_fall;
  logic                     at_start;
  logic                     is_final;
  logic [C_IMG_WBITS-1:0]   col;
  logic [C_IMG_HBITS-1:0]   row;
  logic                     unused_ok;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLEN   = LAST_BEAT;
  assign M_AXI_ARSIZE  = SIZE_ENC;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = AXI_CACHE_MODIFIABLE;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;

  assign r_hs      = M_AXI_RVALID & M_AXI_RREADY;
  assign wr_en     = r_hs & ~resetting;
  assign dout      = M_AXI_RDATA;
  assign sof       = wr_en & sof_pend;
  assign rresp_err = r_hs & (M_AXI_RRESP[1] | (M_AXI_RLAST & (beat_cnt != 8'd0)));
  assign soft_fall = soft_d & ~soft_resetn;
  assign space_ok  = ({1'b0, wr_data_count} + CW'(C_M_AXI_BURST_LEN)) <= CW'(C_FIFO_DEPTH);
  assign unused_ok = ^{M_AXI_RID, M_AXI_RRESP[0], col, row};

  img_pos_counter #(
    .W_BITS (C_IMG_WBITS),
    .H_BITS (C_IMG_HBITS),
    .STEP   (C_ADATA_PIXELS)
  ) u_pos (
    .clk      (M_AXI_ACLK),
    .rst_n    (M_AXI_ARESETN),
    .clear    (~soft_resetn),
    .load     ((state == ST_START) & at_start),
    .dec      (wr_en),
    .width    (img_width),
    .height   (img_height),
    .col      (col),
    .row      (row),
    .at_start (at_start),
    .is_final (is_final)
  );

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= ST_IDLE;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      beat_cnt      <= 8'd0;
      sof_pend      <= 1'b0;
      soft_d        <= 1'b1;
      resetting     <= 1'b1;
      frame_pulse   <= 1'b0;
    end else begin
      soft_d      <= soft_resetn;
      frame_pulse <= is_final;
      // A soft reset mid-burst lets the burst drain on AXI; later assignments clear it at RLAST.
      if (soft_fall && state != ST_IDLE) resetting <= 1'b1;
      case (state)
        ST_IDLE: begin
          resetting <= 1'b0;
          if (soft_resetn && !resetting && img_width != '0 && img_height != '0 && space_ok)
            state <= ST_START;
        end
        ST_START: begin
          M_AXI_ARADDR  <= at_start ? base_addr : M_AXI_ARADDR + BURST_BYTES;
          beat_cnt      <= LAST_BEAT;
          sof_pend      <= at_start;
          M_AXI_ARVALID <= 1'b1;
          state         <= ST_ADDR;
        end
        ST_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            sof_pend <= 1'b0;
            if (beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
            if (M_AXI_RLAST) begin
              M_AXI_RREADY <= 1'b0;
              resetting    <= 1'b0;
              state        <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm2fifo.sv
// Directed bench for mm2fifo: 8x2 frame, 4 pixels/word, 2-beat bursts, simple AXI read responder.
module tb_mm2fifo;

  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        soft_resetn = 1'b1;
  logic        resetting;
  logic [11:0] img_width, img_height;
  logic [31:0] base_addr;
  logic        frame_pulse;
  logic [31:0] dout;
  logic        sof, wr_en;
  logic [11:0] wr_data_count;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid, arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, rresp_err;

  mm2fifo #(.C_M_AXI_BURST_LEN(BL)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(arst_n), .soft_resetn(soft_resetn), .resetting(resetting),
    .img_width(img_width), .img_height(img_height), .base_addr(base_addr),
    .frame_pulse(frame_pulse), .dout(dout), .sof(sof), .wr_en(wr_en), .wr_data_count(wr_data_count),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
    .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .rresp_err(rresp_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Responder state; per-burst length/error beat are latched at the AR handshake.
  int          cyc = 0;
  int          ar_delay = 0, ar_cnt = 0;
  int          cfg_nb = BL, cfg_err = -1;
  bit          s_inb = 1'b0;
  int          s_beat = 0, s_nb = BL, s_err = -1;
  logic [31:0] s_addr = 32'h0;
  bit          hs_r;
  int          hs_beat;

  logic [31:0] ar_q[$];
  int          arcyc_q[$];
  logic [31:0] dout_q[$];
  bit          sof_q[$];
  int          wrcyc_q[$];
  int          fp_q[$];

  int          c0;
  logic [31:0] a0;
  bit          stable;
  logic [31:0] exp_dout[4];
  bit          exp_sof[4];

  task automatic clear_logs();
    ar_q.delete(); arcyc_q.delete(); dout_q.delete();
    sof_q.delete(); wrcyc_q.delete(); fp_q.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    arready = (ar_delay == 0) || (arvalid && ar_cnt >= ar_delay);
    rvalid  = s_inb;
    rlast   = s_inb && (s_beat == s_nb - 1);
    rdata   = s_addr + 32'(4 * s_beat);
    rresp   = (s_inb && s_beat == s_err) ? 2'b10 : 2'b00;
    #1;
    hs_r    = rvalid && rready;
    hs_beat = s_beat;
    if (wr_en) begin
      dout_q.push_back(dout);
      sof_q.push_back(sof);
      wrcyc_q.push_back(cyc);
    end
    if (frame_pulse) fp_q.push_back(cyc);
    if (arvalid && arready) begin
      ar_q.push_back(araddr);
      arcyc_q.push_back(cyc);
      s_inb = 1'b1; s_beat = 0; s_addr = araddr; s_nb = cfg_nb; s_err = cfg_err; ar_cnt = 0;
    end else if (arvalid) begin
      ar_cnt++;
    end
    if (hs_r) begin
      if (rlast) s_inb = 1'b0;
      s_beat++;
    end
  endtask

  task automatic wait_idle();
    wr_data_count = 12'd2047;
    repeat (16) tick();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk_eq({pfx, "_arvalid"}, arvalid, 0);
    chk_eq({pfx, "_rready"}, rready, 0);
    chk_eq({pfx, "_araddr"}, araddr, 0);
    chk_eq({pfx, "_wr_en"}, wr_en, 0);
    chk_eq({pfx, "_sof"}, sof, 0);
    chk_eq({pfx, "_frame_pulse"}, frame_pulse, 0);
    chk_eq({pfx, "_rresp_err"}, rresp_err, 0);
    chk_eq({pfx, "_resetting"}, resetting, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    img_width = 12'd8; img_height = 12'd2; base_addr = 32'h1000; wr_data_count = 12'd0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00; rid = '0;
    exp_dout = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    exp_sof  = '{1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state and AR constants.
    repeat (3) tick();
    chk_reset_outputs("rst");
    chk_eq("arid", arid, 0);
    chk_eq("arlen", arlen, 1);
    chk_eq("arsize", arsize, 2);
    chk_eq("arburst", arburst, 1);
    chk_eq("arlock", arlock, 0);
    chk_eq("arcache", arcache, 4'b0010);
    chk_eq("arprot", arprot, 0);
    chk_eq("arqos", arqos, 0);
    arst_n = 1'b1;
    tick();
    chk_eq("rst_release_resetting", resetting, 0);

    // One full frame plus the start of the next.
    for (int i = 0; i < 60 && ar_q.size() < 3; i++) tick();
    chk_eq("s1_ar_count", ar_q.size(), 3);
    if (ar_q.size() >= 3) begin
      chk_eq("s1_ar0", ar_q[0], 32'h1000);
      chk_eq("s1_ar1", ar_q[1], 32'h1008);
      chk_eq("s1_ar2_wrap", ar_q[2], 32'h1000);
    end
    chk_eq("s1_wr_beats", wrcyc_q.size(), 4);
    if (wrcyc_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk_eq($sformatf("s1_dout%0d", i), dout_q[i], exp_dout[i]);
        chk_eq($sformatf("s1_sof%0d", i), sof_q[i], exp_sof[i]);
      end
      chk_eq("s1_fp_count", fp_q.size(), 1);
      if (fp_q.size() >= 1) chk_eq("s1_fp_timing", fp_q[0], wrcyc_q[3] + 1);
    end

    // FIFO space gating: one word short blocks, then issue 2 cycles after room appears.
    wr_data_count = 12'd2047;
    repeat (16) tick();
    clear_logs();
    repeat (8) tick();
    chk_eq("s2_blocked_ar", ar_q.size(), 0);
    chk_eq("s2_blocked_arvalid", arvalid, 0);
    wr_data_count = 12'd2046;
    c0 = cyc;
    for (int i = 0; i < 10 && ar_q.size() == 0; i++) tick();
    chk_eq("s2_ar_seen", ar_q.size(), 1);
    if (ar_q.size() >= 1) begin
      chk_eq("s2_ar_delay", arcyc_q[0] - c0, 2);
      chk_eq("s2_resume_addr", ar_q[0], 32'h1008);
    end

    // ARREADY held off for 5 cycles.
    wait_idle();
    ar_delay = 5;
    clear_logs();
    wr_data_count = 12'd0;
    for (int i = 0; i < 10 && !arvalid; i++) tick();
    chk_eq("s3_arvalid_up", arvalid, 1);
    a0 = araddr;
    stable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (!(arvalid && araddr == a0 && !rready)) stable = 1'b0;
    end
    chk_eq("s3_hold_stable", stable, 1);
    chk_eq("s3_handshake", ar_q.size(), 1);
    tick();
    chk_eq("s3_rready_after", rready, 1);
    chk_eq("s3_arvalid_drop", arvalid, 0);
    ar_delay = 0;

    // Soft reset in the middle of a burst.
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hs_r && hs_beat == 0) break;
    end
    chk_eq("s4_beat0_found", hs_r, 1);
    chk_eq("s4_beat0_written", wr_en, 1);
    soft_resetn = 1'b0;
    tick();
    chk_eq("s4_resetting_set", resetting, 1);
    chk_eq("s4_beat_accepted", hs_r, 1);
    chk_eq("s4_beat_dropped", wr_en, 0);
    soft_resetn = 1'b1;
    tick();
    chk_eq("s4_resetting_clear", resetting, 0);
    clear_logs();
    for (int i = 0; i < 10 && ar_q.size() == 0; i++) tick();
    chk_eq("s4_restart_seen", ar_q.size(), 1);
    if (ar_q.size() >= 1) chk_eq("s4_restart_base", ar_q[0], 32'h1000);
    for (int i = 0; i < 10 && sof_q.size() == 0; i++) tick();
    chk_eq("s4_first_write", sof_q.size(), 1);
    if (sof_q.size() >= 1) chk_eq("s4_sof", sof_q[0], 1);

    // SLVERR-style response on beat 1: flagged for one cycle, data still written.
    cfg_err = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hs_r && hs_beat == 1 && s_err == 1) break;
    end
    chk_eq("s5_err_pulse", rresp_err, 1);
    chk_eq("s5_err_written", wr_en, 1);
    chk_eq("s5_err_data", dout, s_addr + 32'h4);
    cfg_err = -1;
    tick();
    chk_eq("s5_err_one_cycle", rresp_err, 0);

    // RLAST on beat 0 of a 2-beat burst.
    cfg_nb = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hs_r && s_nb == 1) break;
    end
    cfg_nb = BL;
    chk_eq("s6_early_rlast", rlast, 1);
    chk_eq("s6_early_err", rresp_err, 1);
    tick();
    chk_eq("s6_rready_drop", rready, 0);
    chk_eq("s6_err_cleared", rresp_err, 0);
    clear_logs();
    for (int i = 0; i < 10 && ar_q.size() == 0; i++) tick();
    chk_eq("s6_next_burst", ar_q.size(), 1);

    // Hard reset in the middle of the data phase, checked between clock edges.
    for (int i = 0; i < 20 && !rready; i++) tick();
    chk_eq("s7_in_data", rready, 1);
    #2;
    arst_n = 1'b0;
    #1;
    chk_reset_outputs("s7");
    s_inb = 1'b0;
    ar_cnt = 0;
    repeat (2) tick();
    arst_n = 1'b1;
    tick();
    chk_eq("s7_release_resetting", resetting, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
